id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus EX-stage operand selection.
- Latches decoded instruction fields from ID and resolves data hazards by forwarding from MEM and WB.
- Drives the ALU's operation code and both operands (aluOpE, SrcA, SrcB) and the store data for MEM.
- Stall and flush inputs come from the external hazard unit.

Parameters:
- DW, 32, data word width; equals `WORD_WIDTH.
- OPW, 4, ALU op code width; equals `ALU_OP_LENGTH.
- RW, 5, register-index width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stallE  in  1  hold the E-stage contents.
- flushE  in  1  insert a bubble into E.
- validD  in  1  ID holds a real instruction.
- aluOpD  in  OPW  ALU operation.
- rsD, rtD, writeRegD  in  RW  source and destination register indices.
- rsDataD, rtDataD  in  DW  register-file read data.
- immD  in  DW  extended immediate.
- shamtD  in  5  shift amount field.
- aluSrcBImmD  in  1  SrcB takes the immediate.
- aluSrcAShamtD  in  1  SrcA takes the zero-extended shamt.
- regWriteD, memToRegD, memWriteD  in  1  control bits.
- regWriteM  in  1  MEM-stage write enable.
- writeRegM  in  RW  MEM-stage destination index.
- aluOutM  in  DW  MEM-stage ALU result.
- regWriteW  in  1  WB-stage write enable.
- writeRegW  in  RW  WB-stage destination index.
- resultW  in  DW  WB-stage result.
- validE  out  1  E holds a real instruction.
- aluOpE  out  OPW  to ALU.
- SrcA, SrcB  out  DW  to ALU.
- writeDataE  out  DW  forwarded rt value, for stores.
- writeRegE  out  RW  destination index.
- rsE, rtE  out  RW  to the hazard unit.
- regWriteE, memToRegE, memWriteE  out  1  control bits.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All E registers clear to 0.
  - aluOpE = `ALU_NOP; validE = 0.
  - SrcA, SrcB and writeDataE read 0 because the forwarding selects are 0 while all indices are 0.
- Register update, each rising clk, in priority order:
  - flushE = 1: load a bubble. validE = 0, regWriteE = 0, memWriteE = 0, memToRegE = 0, aluOpE = `ALU_NOP, all indices 0. flushE wins over stallE.
  - Else stallE = 1: hold every field except the rsData/rtData holding registers. These reload with the currently forwarded values fwdA/fwdB (capture-on-stall), so a producer retiring from WB during the stall is not lost.
  - Else: load every D-side field (the *D inputs) into its E register.
- Latency: exactly one cycle from D inputs to E outputs when not stalled.
- Forwarding, combinational from the E registers; computed identically for rs (giving fwdA) and rt (giving fwdB):
  - Select aluOutM if regWriteM, writeRegM != 0 and writeRegM == rsE.
  - Else select resultW if regWriteW, writeRegW != 0 and writeRegW == rsE.
  - Else select the registered rsDataE.
  - MEM has priority over WB.
  - Register 0 is never forwarded.
- Operand muxing:
  - SrcA = aluSrcAShamtE ? {27'b0, shamtE} : fwdA. The ALU takes the shift amount from SrcA[4:0] and the shifted value from SrcB.
  - SrcB = aluSrcBImmE ? immE : fwdB.
  - writeDataE = fwdB always, independent of aluSrcBImmE.
- Load-use hazards: the hazard unit guarantees no load result sits in MEM when it is consumed. This block does not check; a violation forwards aluOutM, i.e. the address.
- Operand datapath is purely combinational; no arithmetic inside the block.
- Reset mid-stall: reset dominates, and the E stage comes up empty.

Decomposition:
- Shared defines header holds `WORD_WIDTH, `ALU_OP_LENGTH, `ZEROWORD and the ALU op codes; add `ALU_NOP = 4'hF, an unused code for which the ALU outputs 0.
- Add forwarding-select localparams FWD_REG = 2'd0, FWD_WB = 2'd1, FWD_MEM = 2'd2 to the same header.
- One natural sub-module: fwd_select, instantiated twice. Inputs: source index, registered data, the M/W write info and data. Outputs: the 2-bit select and the forwarded word.

Test Plan:
- Plain path: ADD, rsD = 3, rsDataD = 0x10, rtDataD = 0x22, no producers in M/W -> next cycle SrcA = 0x10, SrcB = 0x22, validE = 1.
- MEM beats WB: rsE = 5; regWriteM = 1, writeRegM = 5, aluOutM = 0xAAAA; regWriteW = 1, writeRegW = 5, resultW = 0xBBBB -> SrcA = 0xAAAA. Drop regWriteM -> SrcA = 0xBBBB.
- Zero register: rtE = 0, writeRegM = 0, regWriteM = 1, aluOutM = 0xFFFF, rtDataE = 0 -> SrcB = 0 and writeDataE = 0.
- Shift and immediate: aluSrcAShamtD = 1, shamtD = 7, rtDataD = 0x1; aluSrcBImmD = 1, immD = 0x40 -> SrcA = 0x7, SrcB = 0x40, writeDataE = 0x1.
- Capture-on-stall: rsE = 9 with WB forwarding resultW = 0x1234, stallE = 1 for 2 cycles while W changes to an unrelated reg -> SrcA stays 0x1234 throughout.
- Flush and async reset: flushE = 1 together with stallE = 1 -> validE = 0, regWriteE = 0, aluOpE = 4'hF. Reset pulse between clock edges -> all outputs 0 or NOP immediately, not at the next edge.

Source files
------------

// File: rtl/id_ex_operand_stage_pkg.sv
// Shared widths, ALU op codes and forwarding-select codes for the ID/EX operand stage.
package id_ex_operand_stage_pkg;

    localparam int WORD_WIDTH    = 32;
    localparam int ALU_OP_LENGTH = 4;
    localparam int REG_IDX_WIDTH = 5;

    localparam logic [31:0] ZEROWORD = 32'h0000_0000;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_XOR = 4'h4;
    localparam logic [3:0] ALU_SLL = 4'h5;
    localparam logic [3:0] ALU_SRL = 4'h6;
    localparam logic [3:0] ALU_SRA = 4'h7;
    localparam logic [3:0] ALU_SLT = 4'h8;
    // Unused op code; the ALU drives 0 for it, so a bubble is harmless downstream.
    localparam logic [3:0] ALU_NOP = 4'hF;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    // A later stage supplies the operand only if it writes a non-zero register matching the source.
    function automatic logic fwd_hit(input logic we, input logic [4:0] dst, input logic [4:0] src);
        return we && (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Decode-side, MEM/WB forwarding and E-stage signals of the ID/EX operand stage.
interface id_ex_operand_stage_if
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DW  = WORD_WIDTH,
    parameter int OPW = ALU_OP_LENGTH,
    parameter int RW  = REG_IDX_WIDTH
);
    logic           stallE;
    logic           flushE;
    logic           validD;
    logic [OPW-1:0] aluOpD;
    logic [RW-1:0]  rsD;
    logic [RW-1:0]  rtD;
    logic [RW-1:0]  writeRegD;
    logic [DW-1:0]  rsDataD;
    logic [DW-1:0]  rtDataD;
    logic [DW-1:0]  immD;
    logic [4:0]     shamtD;
    logic           aluSrcBImmD;
    logic           aluSrcAShamtD;
    logic           regWriteD;
    logic           memToRegD;
    logic           memWriteD;
    logic           regWriteM;
    logic [RW-1:0]  writeRegM;
    logic [DW-1:0]  aluOutM;
    logic           regWriteW;
    logic [RW-1:0]  writeRegW;
    logic [DW-1:0]  resultW;

    logic           validE;
    logic [OPW-1:0] aluOpE;
    logic [DW-1:0]  SrcA;
    logic [DW-1:0]  SrcB;
    logic [DW-1:0]  writeDataE;
    logic [RW-1:0]  writeRegE;
    logic [RW-1:0]  rsE;
    logic [RW-1:0]  rtE;
    logic           regWriteE;
    logic           memToRegE;
    logic           memWriteE;

    modport master (
        output stallE, flushE, validD, aluOpD, rsD, rtD, writeRegD, rsDataD, rtDataD,
               immD, shamtD, aluSrcBImmD, aluSrcAShamtD, regWriteD, memToRegD, memWriteD,
               regWriteM, writeRegM, aluOutM, regWriteW, writeRegW, resultW,
        input  validE, aluOpE, SrcA, SrcB, writeDataE, writeRegE, rsE, rtE,
               regWriteE, memToRegE, memWriteE
    );

    modport slave (
        input  stallE, flushE, validD, aluOpD, rsD, rtD, writeRegD, rsDataD, rtDataD,
               immD, shamtD, aluSrcBImmD, aluSrcAShamtD, regWriteD, memToRegD, memWriteD,
               regWriteM, writeRegM, aluOutM, regWriteW, writeRegW, resultW,
        output validE, aluOpE, SrcA, SrcB, writeDataE, writeRegE, rsE, rtE,
               regWriteE, memToRegE, memWriteE
    );

endinterface

// File: rtl/id_ex_operand_stage_fwd_select.sv
// Per-operand bypass selection: MEM result, then WB result, then the registered read data.
module fwd_select
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DW = WORD_WIDTH,
    parameter int RW = REG_IDX_WIDTH
) (
    input  logic [RW-1:0] src_idx,
    input  logic [DW-1:0] reg_data,
    input  logic          reg_write_m,
    input  logic [RW-1:0] write_reg_m,
    input  logic [DW-1:0] alu_out_m,
    input  logic          reg_write_w,
    input  logic [RW-1:0] write_reg_w,
    input  logic [DW-1:0] result_w,
    output logic [1:0]    sel,
    output logic [DW-1:0] data
);

    // Priority select: the younger MEM producer shadows WB.
    always_comb begin
        sel = FWD_REG;
        if (fwd_hit(reg_write_m, write_reg_m, src_idx)) begin
            sel = FWD_MEM;
        end else if (fwd_hit(reg_write_w, write_reg_w, src_idx)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_REG;
        end
    end

    // Data mux driven by the select.
    always_comb begin
        data = reg_data;
        case (sel)
            FWD_MEM: data = alu_out_m;
            FWD_WB:  data = result_w;
            FWD_REG: data = reg_data;
            default: data = reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB forwarding and ALU operand selection.
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DW  = WORD_WIDTH,
    parameter int OPW = ALU_OP_LENGTH,
    parameter int RW  = REG_IDX_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    id_ex_operand_stage_if.slave  bus
);

    logic           valid_r;
    logic [OPW-1:0] alu_op_r;
    logic [RW-1:0]  rs_r;
    logic [RW-1:0]  rt_r;
    logic [RW-1:0]  write_reg_r;
    logic [DW-1:0]  rs_data_r;
    logic [DW-1:0]  rt_data_r;
    logic [DW-1:0]  imm_r;
    logic [4:0]     shamt_r;
    logic           src_b_imm_r;
    logic           src_a_shamt_r;
    logic           reg_write_r;
    logic           mem_to_reg_r;
    logic           mem_write_r;

    logic [1:0]     fwd_sel_a_s;
    logic [1:0]     fwd_sel_b_s;
    logic [DW-1:0]  fwd_a_s;
    logic [DW-1:0]  fwd_b_s;

    // E-stage register: flush beats stall; a stall refreshes read data with any bypassed value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r       <= 1'b0;
            alu_op_r      <= ALU_NOP;
            rs_r          <= '0;
            rt_r          <= '0;
            write_reg_r   <= '0;
            rs_data_r     <= '0;
            rt_data_r     <= '0;
            imm_r         <= '0;
            shamt_r       <= 5'd0;
            src_b_imm_r   <= 1'b0;
            src_a_shamt_r <= 1'b0;
            reg_write_r   <= 1'b0;
            mem_to_reg_r  <= 1'b0;
            mem_write_r   <= 1'b0;
        end else if (bus.flushE) begin
            valid_r       <= 1'b0;
            alu_op_r      <= ALU_NOP;
            rs_r          <= '0;
            rt_r          <= '0;
            write_reg_r   <= '0;
            rs_data_r     <= '0;
            rt_data_r     <= '0;
            imm_r         <= '0;
            shamt_r       <= 5'd0;
            src_b_imm_r   <= 1'b0;
            src_a_shamt_r <= 1'b0;
            reg_write_r   <= 1'b0;
            mem_to_reg_r  <= 1'b0;
            mem_write_r   <= 1'b0;
        end else if (bus.stallE) begin
            // Capture a retiring producer now; it will be gone once the stall releases.
            rs_data_r <= (fwd_sel_a_s == FWD_REG) ? rs_data_r : fwd_a_s;
            rt_data_r <= (fwd_sel_b_s == FWD_REG) ? rt_data_r : fwd_b_s;
        end else begin
            valid_r       <= bus.validD;
            alu_op_r      <= bus.aluOpD;
            rs_r          <= bus.rsD;
            rt_r          <= bus.rtD;
            write_reg_r   <= bus.writeRegD;
            rs_data_r     <= bus.rsDataD;
            rt_data_r     <= bus.rtDataD;
            imm_r         <= bus.immD;
            shamt_r       <= bus.shamtD;
            src_b_imm_r   <= bus.aluSrcBImmD;
            src_a_shamt_r <= bus.aluSrcAShamtD;
            reg_write_r   <= bus.regWriteD;
            mem_to_reg_r  <= bus.memToRegD;
            mem_write_r   <= bus.memWriteD;
        end
    end

    fwd_select #(.DW(DW), .RW(RW)) u_fwd_a (
        .src_idx     (rs_r),
        .reg_data    (rs_data_r),
        .reg_write_m (bus.regWriteM),
        .write_reg_m (bus.writeRegM),
        .alu_out_m   (bus.aluOutM),
        .reg_write_w (bus.regWriteW),
        .write_reg_w (bus.writeRegW),
        .result_w    (bus.resultW),
        .sel         (fwd_sel_a_s),
        .data        (fwd_a_s)
    );

    fwd_select #(.DW(DW), .RW(RW)) u_fwd_b (
        .src_idx     (rt_r),
        .reg_data    (rt_data_r),
        .reg_write_m (bus.regWriteM),
        .write_reg_m (bus.writeRegM),
        .alu_out_m   (bus.aluOutM),
        .reg_write_w (bus.regWriteW),
        .write_reg_w (bus.writeRegW),
        .result_w    (bus.resultW),
        .sel         (fwd_sel_b_s),
        .data        (fwd_b_s)
    );

    assign bus.SrcA       = src_a_shamt_r ? {{(DW-5){1'b0}}, shamt_r} : fwd_a_s;
    assign bus.SrcB       = src_b_imm_r ? imm_r : fwd_b_s;
    assign bus.writeDataE = fwd_b_s;
    assign bus.validE     = valid_r;
    assign bus.aluOpE     = alu_op_r;
    assign bus.writeRegE  = write_reg_r;
    assign bus.rsE        = rs_r;
    assign bus.rtE        = rt_r;
    assign bus.regWriteE  = reg_write_r;
    assign bus.memToRegE  = mem_to_reg_r;
    assign bus.memWriteE  = mem_write_r;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_id_ex_operand_stage;
    import id_ex_operand_stage_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    id_ex_operand_stage_if bus ();

    id_ex_operand_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural view of the instruction held in E.
    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic [4:0]  rs, rt, wr, shamt;
        logic [31:0] rsv, rtv, imm;
        logic        bimm, ashamt, regw, m2r, memw;
    } einstr_t;

    einstr_t m;

    function automatic einstr_t empty_instr();
        einstr_t e;
        e.valid = 1'b0; e.op = 4'hF; e.rs = 5'd0; e.rt = 5'd0; e.wr = 5'd0; e.shamt = 5'd0;
        e.rsv = 32'd0; e.rtv = 32'd0; e.imm = 32'd0;
        e.bimm = 1'b0; e.ashamt = 1'b0; e.regw = 1'b0; e.m2r = 1'b0; e.memw = 1'b0;
        return e;
    endfunction

    // Value register idx holds as seen by E: youngest in-flight writer wins, r0 is never bypassed.
    function automatic logic [31:0] seen(input logic [4:0] idx, input logic [31:0] rf);
        if (bus.regWriteM && idx != 5'd0 && bus.writeRegM == idx) return bus.aluOutM;
        if (bus.regWriteW && idx != 5'd0 && bus.writeRegW == idx) return bus.resultW;
        return rf;
    endfunction

    function automatic logic [31:0] exp_a();
        return m.ashamt ? {27'd0, m.shamt} : seen(m.rs, m.rsv);
    endfunction

    function automatic logic [31:0] exp_b();
        return m.bimm ? m.imm : seen(m.rt, m.rtv);
    endfunction

    task automatic tick();
        einstr_t n;
        n = m;
        if (bus.flushE) begin
            n = empty_instr();
        end else if (bus.stallE) begin
            n.rsv = seen(m.rs, m.rsv);
            n.rtv = seen(m.rt, m.rtv);
        end else begin
            n.valid = bus.validD; n.op = bus.aluOpD; n.rs = bus.rsD; n.rt = bus.rtD;
            n.wr = bus.writeRegD; n.shamt = bus.shamtD; n.rsv = bus.rsDataD; n.rtv = bus.rtDataD;
            n.imm = bus.immD; n.bimm = bus.aluSrcBImmD; n.ashamt = bus.aluSrcAShamtD;
            n.regw = bus.regWriteD; n.m2r = bus.memToRegD; n.memw = bus.memWriteD;
        end
        @(posedge clk);
        m = n;
        #1;
    endtask

    task automatic clear_inputs();
        bus.stallE = 1'b0; bus.flushE = 1'b0; bus.validD = 1'b0; bus.aluOpD = ALU_ADD;
        bus.rsD = 5'd0; bus.rtD = 5'd0; bus.writeRegD = 5'd0; bus.rsDataD = 32'd0;
        bus.rtDataD = 32'd0; bus.immD = 32'd0; bus.shamtD = 5'd0; bus.aluSrcBImmD = 1'b0;
        bus.aluSrcAShamtD = 1'b0; bus.regWriteD = 1'b0; bus.memToRegD = 1'b0; bus.memWriteD = 1'b0;
        bus.regWriteM = 1'b0; bus.writeRegM = 5'd0; bus.aluOutM = 32'd0;
        bus.regWriteW = 1'b0; bus.writeRegW = 5'd0; bus.resultW = 32'd0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        m = empty_instr();
        bus.regWriteM = 1'b1; bus.writeRegM = 5'd0; bus.aluOutM = 32'hDEAD_BEEF;
        #12;
        total++; if (bus.validE !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.validE); end
        total++; if (bus.aluOpE !== 4'hF) begin bad++; $display("FAIL reset_aluop got=%h exp=f", bus.aluOpE); end
        total++; if (bus.SrcA !== 32'd0 || bus.SrcB !== 32'd0 || bus.writeDataE !== 32'd0) begin
            bad++; $display("FAIL reset_operands got=%h/%h/%h exp=0", bus.SrcA, bus.SrcB, bus.writeDataE); end
        total++; if ({bus.regWriteE, bus.memToRegE, bus.memWriteE, bus.rsE, bus.rtE, bus.writeRegE} !== 18'd0) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=0", {bus.regWriteE, bus.memToRegE, bus.memWriteE}); end
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_plain();
        clear_inputs();
        bus.validD = 1'b1; bus.aluOpD = ALU_ADD; bus.rsD = 5'd3; bus.rtD = 5'd4; bus.writeRegD = 5'd6;
        bus.rsDataD = 32'h10; bus.rtDataD = 32'h22; bus.regWriteD = 1'b1;
        tick();
        total++; if (bus.SrcA !== 32'h10) begin bad++; $display("FAIL plain_srca got=%h exp=10", bus.SrcA); end
        total++; if (bus.SrcB !== 32'h22) begin bad++; $display("FAIL plain_srcb got=%h exp=22", bus.SrcB); end
        total++; if (bus.validE !== 1'b1 || bus.rsE !== 5'd3 || bus.writeRegE !== 5'd6 || bus.regWriteE !== 1'b1) begin
            bad++; $display("FAIL plain_fields got=%b/%0d/%0d exp=1/3/6", bus.validE, bus.rsE, bus.writeRegE); end
    endtask

    task automatic test_mem_over_wb();
        clear_inputs();
        bus.validD = 1'b1; bus.rsD = 5'd5; bus.rsDataD = 32'h55;
        tick();
        bus.regWriteM = 1'b1; bus.writeRegM = 5'd5; bus.aluOutM = 32'hAAAA;
        bus.regWriteW = 1'b1; bus.writeRegW = 5'd5; bus.resultW = 32'hBBBB;
        #1;
        total++; if (bus.SrcA !== 32'hAAAA) begin bad++; $display("FAIL mem_priority got=%h exp=aaaa", bus.SrcA); end
        bus.regWriteM = 1'b0;
        #1;
        total++; if (bus.SrcA !== 32'hBBBB) begin bad++; $display("FAIL wb_forward got=%h exp=bbbb", bus.SrcA); end
        bus.regWriteW = 1'b0;
        #1;
        total++; if (bus.SrcA !== 32'h55) begin bad++; $display("FAIL no_forward got=%h exp=55", bus.SrcA); end
    endtask

    task automatic test_zero_reg();
        clear_inputs();
        bus.validD = 1'b1; bus.rtD = 5'd0; bus.rtDataD = 32'd0;
        tick();
        bus.regWriteM = 1'b1; bus.writeRegM = 5'd0; bus.aluOutM = 32'hFFFF;
        bus.regWriteW = 1'b1; bus.writeRegW = 5'd0; bus.resultW = 32'h7777;
        #1;
        total++; if (bus.SrcB !== 32'd0 || bus.writeDataE !== 32'd0) begin
            bad++; $display("FAIL zero_reg got=%h/%h exp=0/0", bus.SrcB, bus.writeDataE); end
    endtask

    task automatic test_shift_imm();
        clear_inputs();
        bus.validD = 1'b1; bus.aluOpD = ALU_SLL; bus.rsD = 5'd3; bus.rsDataD = 32'hDEAD;
        bus.rtD = 5'd2; bus.rtDataD = 32'h1; bus.aluSrcAShamtD = 1'b1; bus.shamtD = 5'd7;
        bus.aluSrcBImmD = 1'b1; bus.immD = 32'h40; bus.memWriteD = 1'b1;
        tick();
        total++; if (bus.SrcA !== 32'h7) begin bad++; $display("FAIL shamt_srca got=%h exp=7", bus.SrcA); end
        total++; if (bus.SrcB !== 32'h40) begin bad++; $display("FAIL imm_srcb got=%h exp=40", bus.SrcB); end
        total++; if (bus.writeDataE !== 32'h1) begin bad++; $display("FAIL store_data got=%h exp=1", bus.writeDataE); end
        bus.regWriteW = 1'b1; bus.writeRegW = 5'd2; bus.resultW = 32'h99;
        #1;
        total++; if (bus.writeDataE !== 32'h99 || bus.SrcB !== 32'h40) begin
            bad++; $display("FAIL store_fwd got=%h/%h exp=99/40", bus.writeDataE, bus.SrcB); end
    endtask

    task automatic test_capture_on_stall();
        clear_inputs();
        bus.validD = 1'b1; bus.rsD = 5'd9; bus.rsDataD = 32'h1;
        tick();
        bus.regWriteW = 1'b1; bus.writeRegW = 5'd9; bus.resultW = 32'h1234;
        bus.stallE = 1'b1; bus.rsD = 5'd1; bus.rsDataD = 32'h5;
        #1;
        total++; if (bus.SrcA !== 32'h1234) begin bad++; $display("FAIL stall_pre got=%h exp=1234", bus.SrcA); end
        tick();
        bus.writeRegW = 5'd12; bus.resultW = 32'h9999;
        #1;
        total++; if (bus.SrcA !== 32'h1234) begin bad++; $display("FAIL stall_hold1 got=%h exp=1234", bus.SrcA); end
        tick();
        total++; if (bus.SrcA !== 32'h1234 || bus.rsE !== 5'd9) begin
            bad++; $display("FAIL stall_hold2 got=%h rs=%0d exp=1234 rs=9", bus.SrcA, bus.rsE); end
        bus.stallE = 1'b0;
        tick();
        total++; if (bus.SrcA !== 32'h5 || bus.rsE !== 5'd1) begin
            bad++; $display("FAIL stall_release got=%h rs=%0d exp=5 rs=1", bus.SrcA, bus.rsE); end
    endtask

    task automatic test_flush();
        clear_inputs();
        bus.validD = 1'b1; bus.aluOpD = ALU_SUB; bus.rsD = 5'd4; bus.regWriteD = 1'b1; bus.memWriteD = 1'b1;
        tick();
        bus.stallE = 1'b1; bus.flushE = 1'b1;
        tick();
        total++; if (bus.validE !== 1'b0 || bus.regWriteE !== 1'b0 || bus.memWriteE !== 1'b0) begin
            bad++; $display("FAIL flush_ctrl got=%b%b%b exp=000", bus.validE, bus.regWriteE, bus.memWriteE); end
        total++; if (bus.aluOpE !== 4'hF || bus.rsE !== 5'd0) begin
            bad++; $display("FAIL flush_op got=%h rs=%0d exp=f rs=0", bus.aluOpE, bus.rsE); end
    endtask

    task automatic test_async_reset();
        clear_inputs();
        bus.validD = 1'b1; bus.aluOpD = ALU_OR; bus.rsD = 5'd7; bus.rsDataD = 32'h1111;
        bus.regWriteD = 1'b1; bus.memToRegD = 1'b1;
        tick();
        bus.stallE = 1'b1; bus.regWriteM = 1'b1; bus.writeRegM = 5'd7; bus.aluOutM = 32'h4242;
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (bus.validE !== 1'b0 || bus.aluOpE !== 4'hF || bus.memToRegE !== 1'b0) begin
            bad++; $display("FAIL async_rst_ctrl got=%b/%h exp=0/f", bus.validE, bus.aluOpE); end
        total++; if (bus.SrcA !== 32'd0 || bus.rsE !== 5'd0) begin
            bad++; $display("FAIL async_rst_srca got=%h exp=0", bus.SrcA); end
        m = empty_instr();
        @(posedge clk); #1;
        total++; if (bus.validE !== 1'b0) begin bad++; $display("FAIL rst_hold got=%b exp=0", bus.validE); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.stallE = 1'b0;
        @(posedge clk); #1;
        m = empty_instr();
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bus.stallE = ($urandom_range(0, 3) == 0);
            bus.flushE = ($urandom_range(0, 7) == 0);
            bus.validD = $urandom_range(0, 1);
            bus.aluOpD = 4'($urandom_range(0, 15));
            bus.rsD = 5'($urandom_range(0, 7)); bus.rtD = 5'($urandom_range(0, 7));
            bus.writeRegD = 5'($urandom_range(0, 31));
            bus.rsDataD = $urandom; bus.rtDataD = $urandom; bus.immD = $urandom;
            bus.shamtD = 5'($urandom_range(0, 31));
            bus.aluSrcBImmD = $urandom_range(0, 1); bus.aluSrcAShamtD = $urandom_range(0, 1);
            bus.regWriteD = $urandom_range(0, 1); bus.memToRegD = $urandom_range(0, 1);
            bus.memWriteD = $urandom_range(0, 1);
            bus.regWriteM = $urandom_range(0, 1); bus.writeRegM = 5'($urandom_range(0, 7)); bus.aluOutM = $urandom;
            bus.regWriteW = $urandom_range(0, 1); bus.writeRegW = 5'($urandom_range(0, 7)); bus.resultW = $urandom;
            tick();
            bus.regWriteM = $urandom_range(0, 1); bus.writeRegM = 5'($urandom_range(0, 7)); bus.aluOutM = $urandom;
            bus.regWriteW = $urandom_range(0, 1); bus.writeRegW = 5'($urandom_range(0, 7)); bus.resultW = $urandom;
            #1;
            total++; if (bus.SrcA !== exp_a()) begin bad++; $display("FAIL rnd_srca it=%0d got=%h exp=%h", i, bus.SrcA, exp_a()); end
            total++; if (bus.SrcB !== exp_b()) begin bad++; $display("FAIL rnd_srcb it=%0d got=%h exp=%h", i, bus.SrcB, exp_b()); end
            total++; if (bus.writeDataE !== seen(m.rt, m.rtv)) begin
                bad++; $display("FAIL rnd_wdata it=%0d got=%h exp=%h", i, bus.writeDataE, seen(m.rt, m.rtv)); end
            total++; if ({bus.validE, bus.aluOpE, bus.rsE, bus.rtE, bus.writeRegE, bus.regWriteE, bus.memToRegE, bus.memWriteE}
                         !== {m.valid, m.op, m.rs, m.rt, m.wr, m.regw, m.m2r, m.memw}) begin
                bad++; $display("FAIL rnd_fields it=%0d got=%b/%h/%0d/%0d/%0d exp=%b/%h/%0d/%0d/%0d", i,
                                bus.validE, bus.aluOpE, bus.rsE, bus.rtE, bus.writeRegE,
                                m.valid, m.op, m.rs, m.rt, m.wr); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_plain();
        test_mem_over_wb();
        test_zero_reg();
        test_shift_imm();
        test_capture_on_stall();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
